// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - requester and multiplier signal bundle for mul_arbiter
// slave is the arbiter's view; master is the requester/multiplier side.
interface mul_arbiter_if #(
    parameter int DATA_BITS = 32,
    parameter int REQ_NUM   = 4
);
    logic [REQ_NUM-1:0]           req;
    logic [REQ_NUM-1:0]           req_sign;
    logic [REQ_NUM*DATA_BITS-1:0] req_a;
    logic [REQ_NUM*DATA_BITS-1:0] req_b;
    logic [REQ_NUM-1:0]           ack;
    logic [2*DATA_BITS-1:0]       result;
    logic                         err;
    logic                         busy;
    logic [2:0]                   grant_id;
    logic                         mul_en;
    logic                         mul_sign;
    logic [DATA_BITS-1:0]         mul_a;
    logic [DATA_BITS-1:0]         mul_b;
    logic                         mul_done;
    logic [2*DATA_BITS-1:0]       mul_product;

    modport slave (
        input  req, req_sign, req_a, req_b, mul_done, mul_product,
        output ack, result, err, busy, grant_id, mul_en, mul_sign, mul_a, mul_b
    );

    modport master (
        output req, req_sign, req_a, req_b, mul_done, mul_product,
        input  ack, result, err, busy, grant_id, mul_en, mul_sign, mul_a, mul_b
    );
endinterface

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one multiplier among requesters
// One operation in flight; a watchdog turns a silent multiplier into an err reply.
module mul_arbiter #(
    parameter int DATA_BITS = 32,
    parameter int REQ_NUM   = 4,
    parameter int TIMEOUT   = 255
) (
    input logic          clk,
    input logic          rst,
    mul_arbiter_if.slave bus
);
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPLY} state_t;

    state_t                 state_q;
    logic [REQ_NUM-1:0]     ack_q;
    logic [2*DATA_BITS-1:0] result_q;
    logic                   err_q;
    logic                   busy_q;
    logic                   mul_en_q;
    logic                   mul_sign_q;
    logic [DATA_BITS-1:0]   mul_a_q;
    logic [DATA_BITS-1:0]   mul_b_q;
    logic [2:0]             grant_id_q;
    logic [2:0]             last_grant_q;
    logic [WD_W-1:0]        wd_q;

    logic [7:0]             req_ext;
    logic [2:0]             idx;
    logic                   grant_vld_d;
    logic [2:0]             grant_d;
    logic                   sign_d;
    logic [DATA_BITS-1:0]   a_d;
    logic [DATA_BITS-1:0]   b_d;
    logic [WD_W-1:0]        wd_d;
    logic [REQ_NUM-1:0]     ack_d;

    // Scan from the farthest slot down to last_grant+1 so the nearest set bit wins.
    always_comb begin
        req_ext     = 8'(bus.req);
        idx         = 3'd0;
        grant_vld_d = 1'b0;
        grant_d     = 3'd0;
        for (int i = REQ_NUM; i >= 1; i--) begin
            idx = 3'((int'(last_grant_q) + i) % REQ_NUM);
            if (req_ext[idx]) begin
                grant_vld_d = 1'b1;
                grant_d     = idx;
            end
        end
    end

    always_comb begin
        sign_d = 1'b0;
        a_d    = '0;
        b_d    = '0;
        for (int j = 0; j < REQ_NUM; j++) begin
            if (grant_d == 3'(j)) begin
                sign_d = bus.req_sign[j];
                a_d    = bus.req_a[j*DATA_BITS +: DATA_BITS];
                b_d    = bus.req_b[j*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign wd_d  = wd_q + 1'b1;
    assign ack_d = {{(REQ_NUM-1){1'b0}}, 1'b1} << grant_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ack_q        <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            mul_en_q     <= 1'b0;
            mul_sign_q   <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            grant_id_q   <= 3'd0;
            last_grant_q <= 3'(REQ_NUM - 1);
            wd_q         <= '0;
        end else begin
            ack_q    <= '0;
            mul_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        grant_id_q <= grant_d;
                        mul_sign_q <= sign_d;
                        mul_a_q    <= a_d;
                        mul_b_q    <= b_d;
                        mul_en_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_q    <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A completion in the watchdog's final cycle still counts as success.
                    if (bus.mul_done) begin
                        result_q <= bus.mul_product;
                        err_q    <= 1'b0;
                        ack_q    <= ack_d;
                        state_q  <= REPLY;
                    end else begin
                        wd_q <= wd_d;
                        if (wd_d == WD_W'(TIMEOUT)) begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                            ack_q    <= ack_d;
                            state_q  <= REPLY;
                        end
                    end
                end
                REPLY: begin
                    busy_q       <= 1'b0;
                    last_grant_q <= grant_id_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack      = ack_q;
    assign bus.result   = result_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant_id_q;
    assign bus.mul_en   = mul_en_q;
    assign bus.mul_sign = mul_sign_q;
    assign bus.mul_a    = mul_a_q;
    assign bus.mul_b    = mul_b_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - directed self-checking bench for mul_arbiter
// The bench plays both the requesters and a multiplier stub.
module tb_mul_arbiter;
    localparam int DW = 32;
    localparam int RN = 4;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    mul_arbiter_if #(.DATA_BITS(DW), .REQ_NUM(RN)) bus ();

    mul_arbiter #(.DATA_BITS(DW), .REQ_NUM(RN), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] stub_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic set_op(input int i, input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.req_sign[i]       = s;
        bus.req_a[i*DW +: DW] = a;
        bus.req_b[i*DW +: DW] = b;
    endtask

    task automatic wait_en(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.mul_en) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_mul_en_seen"}, 64'(ok), 64'd1);
    endtask

    // Returns at the negedge of the REPLY (ack) cycle.
    task automatic run_op(input string tag, input int gid, input logic [63:0] exp_res,
                          input bit drop_req, input bit poke_a);
        wait_en(tag);
        check({tag, "_grant_id"}, 64'(bus.grant_id), 64'(gid));
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        if (drop_req) bus.req[gid] = 1'b0;
        if (poke_a) bus.req_a[gid*DW +: DW] = 32'h7;
        @(negedge clk);
        check({tag, "_mul_en_pulse"}, 64'(bus.mul_en), 64'd0);
        bus.mul_done    = 1'b1;
        bus.mul_product = stub_mul(bus.mul_sign, bus.mul_a, bus.mul_b);
        @(negedge clk);
        bus.mul_done    = 1'b0;
        bus.mul_product = '0;
        check({tag, "_ack"}, 64'(bus.ack), 64'(4'b0001 << gid));
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
    endtask

    initial begin
        int early;
        bus.req         = '0;
        bus.req_sign    = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.mul_done    = 1'b0;
        bus.mul_product = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack", 64'(bus.ack), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_mul_en", 64'(bus.mul_en), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_grant_id", 64'(bus.grant_id), 64'd0);
        check("rst_mul_a", 64'(bus.mul_a), 64'd0);
        rst = 1'b0;

        // Single unsigned requester; req dropped before ack still completes
        set_op(1, 1'b0, 32'd3, 32'd5);
        bus.req = 4'b0010;
        run_op("single", 1, 64'd15, 1'b1, 1'b0);
        @(negedge clk);
        check("single_ack_clear", 64'(bus.ack), 64'd0);
        check("single_busy_clear", 64'(bus.busy), 64'd0);

        // Signed then unsigned with identical operands; second pokes req_a after grant
        set_op(2, 1'b1, 32'hFFFF_FFFF, 32'd2);
        bus.req = 4'b0100;
        run_op("signed", 2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
        set_op(2, 1'b0, 32'hFFFF_FFFF, 32'd2);
        bus.req = 4'b0100;
        run_op("unsigned", 2, 64'h0000_0001_FFFF_FFFE, 1'b1, 1'b1);

        // Round robin after reset with req held
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_op(0, 1'b0, 32'd6, 32'd7);
        set_op(2, 1'b0, 32'd9, 32'd9);
        bus.req = 4'b0101;
        run_op("rr0", 0, 64'd42, 1'b0, 1'b0);
        run_op("rr1", 2, 64'd81, 1'b0, 1'b0);
        run_op("rr2", 0, 64'd42, 1'b0, 1'b0);
        run_op("rr3", 2, 64'd81, 1'b0, 1'b0);
        bus.req = '0;

        // Timeout: no mul_done, ack expected TIMEOUT+1 cycles after mul_en
        set_op(0, 1'b0, 32'd4, 32'd4);
        bus.req = 4'b0001;
        wait_en("tmo");
        bus.req = '0;
        early = 0;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (bus.ack != '0) early++;
        end
        check("tmo_no_early_ack", 64'(early), 64'd0);
        @(negedge clk);
        check("tmo_ack", 64'(bus.ack), 64'(4'b0001));
        check("tmo_err", 64'(bus.err), 64'd1);
        check("tmo_result", bus.result, 64'd0);
        @(negedge clk);
        check("tmo_idle_busy", 64'(bus.busy), 64'd0);

        // mul_done in the cycle the watchdog reaches TIMEOUT wins
        bus.req = 4'b0001;
        wait_en("edge");
        bus.req = '0;
        for (int k = 1; k < TO; k++) @(negedge clk);
        @(negedge clk);
        bus.mul_done    = 1'b1;
        bus.mul_product = stub_mul(bus.mul_sign, bus.mul_a, bus.mul_b);
        @(negedge clk);
        bus.mul_done    = 1'b0;
        bus.mul_product = '0;
        check("edge_ack", 64'(bus.ack), 64'(4'b0001));
        check("edge_err", 64'(bus.err), 64'd0);
        check("edge_result", bus.result, 64'd16);

        // Reset mid-WAIT abandons the operation
        @(negedge clk);
        set_op(1, 1'b0, 32'd2, 32'd3);
        bus.req = 4'b0010;
        wait_en("rstw");
        bus.req = '0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstw_busy", 64'(bus.busy), 64'd0);
        check("rstw_ack", 64'(bus.ack), 64'd0);
        check("rstw_result", bus.result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        early = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.ack != '0 || bus.busy) early++;
        end
        check("rstw_quiet", 64'(early), 64'd0);
        set_op(3, 1'b0, 32'd5, 32'd5);
        bus.req = 4'b1000;
        run_op("after_rst", 3, 64'd25, 1'b1, 1'b0);

        // Stray mul_done while idle is ignored
        repeat (2) @(negedge clk);
        bus.mul_done    = 1'b1;
        bus.mul_product = 64'd123;
        @(negedge clk);
        bus.mul_done    = 1'b0;
        bus.mul_product = '0;
        @(negedge clk);
        check("stray_ack", 64'(bus.ack), 64'd0);
        check("stray_busy", 64'(bus.busy), 64'd0);
        check("stray_result", bus.result, 64'd25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter DATA_BITS, default 32: operand width; must match the attached multiplier.
REQ-002 Parameter REQ_NUM, default 4: number of requesters, range 2..8.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for mul_done before an error reply.
REQ-004 clk  input  1  main clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req  input  REQ_NUM  per-requester request level; bit i requests one multiplication.
REQ-007 req_sign  input  REQ_NUM  per-requester signed/unsigned flag; 1 = signed.
REQ-008 req_a  input  REQ_NUM*DATA_BITS  packed multiplicands; requester i occupies slice [i*DATA_BITS +: DATA_BITS].
REQ-009 req_b  input  REQ_NUM*DATA_BITS  packed multipliers, same packing as req_a.
REQ-010 ack  output  REQ_NUM  one-hot, one-cycle completion pulse to the granted requester.
REQ-011 result  output  2*DATA_BITS  product returned with ack; held until the next ack.
REQ-012 err  output  1  timeout flag, valid with ack; held until the next ack.
REQ-013 busy  output  1  high from grant until the ack cycle, inclusive.
REQ-014 grant_id  output  3  index of the current or last granted requester.
REQ-015 mul_en  output  1  one-cycle start pulse to the multiplier.
REQ-016 mul_sign  output  1  registered sign flag to the multiplier.
REQ-017 mul_a  output  DATA_BITS  registered multiplicand to the multiplier.
REQ-018 mul_b  output  DATA_BITS  registered multiplier operand to the multiplier.
REQ-019 mul_done  input  1  one-cycle completion flag from the multiplier.
REQ-020 mul_product  input  2*DATA_BITS  multiplier result; valid in the mul_done cycle.

Function
REQ-021 FSM has four states: IDLE, ISSUE, WAIT and REPLY.
REQ-022 Only one operation is outstanding at a time.
REQ-023 IDLE transition: if any req bit is set, grant the first set bit in round-robin order starting at last_grant+1 (mod REQ_NUM).
REQ-024 On grant: capture that requester's sign, a and b into mul_sign, mul_a and mul_b; set grant_id; go to ISSUE.
REQ-025 IDLE with req all zero: stay in IDLE.
REQ-026 ISSUE: mul_en=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
REQ-027 WAIT with mul_done=1: latch mul_product into result, set err=0, go to REPLY.
REQ-028 WAIT otherwise: increment the watchdog; when it reaches TIMEOUT, set result=0 and err=1, go to REPLY.
REQ-029 Watchdog width is sufficient for TIMEOUT and it does not wrap.
REQ-030 A mul_done arriving in the same cycle the watchdog reaches TIMEOUT counts as success.
REQ-031 REPLY: ack[grant_id]=1 for one cycle, update last_grant=grant_id, go to IDLE.
REQ-032 The next grant occurs no earlier than the IDLE cycle after REPLY.
REQ-033 Latency: ack is asserted exactly one cycle after the mul_done cycle; grant to mul_en is one cycle.
REQ-034 Operands are sampled only in the grant cycle; later changes to req_a, req_b or req_sign do not affect the operation in flight.
REQ-035 A requester that drops req before ack still receives its ack; the operation is not cancelled.
REQ-036 A requester holding req after ack is re-arbitrated fairly; the round-robin pointer excludes it while other requests are pending.
REQ-037 mul_done seen outside WAIT is ignored.
REQ-038 req bits at index ≥ REQ_NUM do not exist; grant_id is always < REQ_NUM.

Reset
REQ-039 rst=1 forces immediately: state IDLE, ack=0, mul_en=0, busy=0, err=0, result=0, mul_a=0, mul_b=0, mul_sign=0, grant_id=0, watchdog=0.
REQ-040 Reset sets last_grant=REQ_NUM-1, so requester 0 has the highest priority first.
REQ-041 Reset during ISSUE, WAIT or REPLY abandons the operation with no ack.
REQ-042 The multiplier is reset by the same rst.

Verification
REQ-043 Single requester, unsigned: req[1]=1, a=3, b=5, sign=0 -> one mul_en, then ack=4'b0010 with result=15, err=0, one cycle after mul_done.
REQ-044 Signed operation: a=32'hFFFFFFFF, b=2, sign=1 -> result=64'hFFFFFFFFFFFFFFFE; the same operands with sign=0 -> result=64'h1FFFFFFFE.
REQ-045 Round-robin after reset: req=4'b0101 held -> grant order 0, 2, 0, 2; each ack is one-hot and never concurrent.
REQ-046 Timeout: multiplier stub never asserts mul_done -> ack with err=1 and result=0 exactly TIMEOUT+1 cycles after mul_en, then IDLE.
REQ-047 Reset mid-WAIT: rst pulse 10 cycles after mul_en -> busy=0 and no ack; a fresh req[3] completes normally afterwards.
REQ-048 Operand stability: change req_a the cycle after grant -> result uses the originally sampled value.
